multiport_regfile: RTL and testbench

Parametrised register file for the datapath, the next generation of the single-write, two-read file. It has a configurable number of combinational read ports and two prioritised write ports. Optional write-to-read bypass and an optional hard-wired zero register are selected by parameter. A per-register busy scoreboard and a sticky write-conflict flag are included. It sits between the decode/issue stage, which reads operands and reserves destinations, and the writeback stage, which drives the two write ports.

---
 rtl/multiport_regfile.sv | 150 +++++++++++++++
 tb/tb_multiport_regfile.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// -----------------------------------------------------------------------------
// multiport_regfile
// Register file with NRD combinational read ports and two prioritised write
// ports (port 1 wins on an index collision). A per-register busy scoreboard
// tracks reserved destinations, and a sticky flag records write conflicts.
//
// Parameters
//   NREGS    number of registers (power of two, >= 2)
//   RSIZE    register width in bits
//   NRD      number of read ports (1..4)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes and reservations
//   BYPASS   1 = a read of an index written this cycle returns the write data
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-low reset
//   we_i       write enable per write port
//   widx_i     write index per port, port p at [p*IW +: IW]
//   wdata_i    write data per port, port p at [p*RSIZE +: RSIZE]
//   ridx_i     read index per read port, port k at [k*IW +: IW]
//   rdata_o    read data per read port (combinational)
//   rbusy_o    busy bit of the register each read port addresses (combinational)
//   rsv_i      reserve a destination register
//   rsv_idx_i  register to reserve
//   busy_o     busy scoreboard (registered)
//   werr_o     sticky write-conflict flag (registered)
// -----------------------------------------------------------------------------
module multiport_regfile #(
  parameter int NREGS    = 8,
  parameter int RSIZE    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int IW      = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           we_i,
  input  logic [2*IW-1:0]      widx_i,
  input  logic [2*RSIZE-1:0]   wdata_i,
  input  logic [NRD*IW-1:0]    ridx_i,
  output logic [NRD*RSIZE-1:0] rdata_o,
  output logic [NRD-1:0]       rbusy_o,
  input  logic                 rsv_i,
  input  logic [IW-1:0]        rsv_idx_i,
  output logic [NREGS-1:0]     busy_o,
  output logic                 werr_o
);

  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  logic [IW-1:0]    w_widx0;
  logic [IW-1:0]    w_widx1;
  logic [RSIZE-1:0] w_wdata0;
  logic [RSIZE-1:0] w_wdata1;
  logic             w_we0;
  logic             w_we1;
  logic             w_rsv;
  logic             w_conflict;
  logic [NREGS-1:0] w_busy_nxt;

  logic [RSIZE-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_werr;

  assign w_widx0  = widx_i[IW-1:0];
  assign w_widx1  = widx_i[2*IW-1:IW];
  assign w_wdata0 = wdata_i[RSIZE-1:0];
  assign w_wdata1 = wdata_i[2*RSIZE-1:RSIZE];

  // Effective enables: nothing is accepted while in reset, and the hard-wired
  // zero register swallows writes and reservations. Killing the enable here
  // also keeps r0 out of the bypass path, the scoreboard and conflict detection.
  assign w_we0 = we_i[0] & rst_i & ~(ZR & (w_widx0 == '0));
  assign w_we1 = we_i[1] & rst_i & ~(ZR & (w_widx1 == '0));
  assign w_rsv = rsv_i & rst_i & ~(ZR & (rsv_idx_i == '0));

  // Both ports landing on the same live register in one cycle.
  assign w_conflict = w_we0 & w_we1 & (w_widx0 == w_widx1);

  // Next scoreboard state: a reserve beats a write to the same register so a
  // destination can be retired and re-issued back to back.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (w_rsv && (rsv_idx_i == IW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((w_we0 && (w_widx0 == IW'(i))) ||
                   (w_we1 && (w_widx1 == IW'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Register storage; port 1 is checked first so it wins an index collision.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we1 && (w_widx1 == IW'(i))) begin
          r_regs[i] <= w_wdata1;
        end else if (w_we0 && (w_widx0 == IW'(i))) begin
          r_regs[i] <= w_wdata0;
        end
      end
    end
  end

  // Scoreboard and sticky conflict flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= '0;
      r_werr <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_werr <= r_werr | w_conflict;
    end
  end

  // Read ports with optional same-cycle bypass (port 1 data preferred).
  // r0 under ZERO_REG is never written, so the stored value is already zero.
  always_comb begin : p_read
    logic [IW-1:0]    w_ridx;
    logic [RSIZE-1:0] w_rdata;
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      w_ridx = ridx_i[k*IW +: IW];
      if (BP && w_we1 && (w_widx1 == w_ridx)) begin
        w_rdata = w_wdata1;
      end else if (BP && w_we0 && (w_widx0 == w_ridx)) begin
        w_rdata = w_wdata0;
      end else begin
        w_rdata = r_regs[w_ridx];
      end
      rdata_o[k*RSIZE +: RSIZE] = w_rdata;
      rbusy_o[k]                = r_busy[w_ridx];
    end
  end

  assign busy_o = r_busy;
  assign werr_o = r_werr;

endmodule

// File: tb/tb_multiport_regfile.sv
`timescale 1ns/1ps
module tb_multiport_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Shared stimulus for two 8x32, 2-read instances:
  //   cfg 0 (u_a): ZERO_REG=1 BYPASS=1    cfg 1 (u_b): ZERO_REG=0 BYPASS=0
  logic [1:0]  we;
  logic [5:0]  widx;
  logic [63:0] wdata;
  logic [5:0]  ridx;
  logic        rsv;
  logic [2:0]  rsv_idx;
  logic [63:0] rd   [2];
  logic [1:0]  rb   [2];
  logic [7:0]  bz   [2];
  logic        werr [2];

  // 16x8, 4-read instance, ZERO_REG=0 BYPASS=1
  logic [1:0]  we_c;
  logic [7:0]  widx_c;
  logic [15:0] wdata_c;
  logic [15:0] ridx_c;
  logic        rsv_c;
  logic [3:0]  rsv_idx_c;
  logic [31:0] rd_c;
  logic [3:0]  rb_c;
  logic [15:0] bz_c;
  logic        werr_c;

  multiport_regfile #(.NREGS(8), .RSIZE(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk_i(clk), .rst_i(rst_n), .we_i(we), .widx_i(widx), .wdata_i(wdata),
    .ridx_i(ridx), .rdata_o(rd[0]), .rbusy_o(rb[0]), .rsv_i(rsv),
    .rsv_idx_i(rsv_idx), .busy_o(bz[0]), .werr_o(werr[0]));

  multiport_regfile #(.NREGS(8), .RSIZE(32), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .we_i(we), .widx_i(widx), .wdata_i(wdata),
    .ridx_i(ridx), .rdata_o(rd[1]), .rbusy_o(rb[1]), .rsv_i(rsv),
    .rsv_idx_i(rsv_idx), .busy_o(bz[1]), .werr_o(werr[1]));

  multiport_regfile #(.NREGS(16), .RSIZE(8), .NRD(4), .ZERO_REG(0), .BYPASS(1)) u_c (
    .clk_i(clk), .rst_i(rst_n), .we_i(we_c), .widx_i(widx_c), .wdata_i(wdata_c),
    .ridx_i(ridx_c), .rdata_o(rd_c), .rbusy_o(rb_c), .rsv_i(rsv_c),
    .rsv_idx_i(rsv_idx_c), .busy_o(bz_c), .werr_o(werr_c));

  // Reference model for cfg 0 / cfg 1
  logic [31:0] m_regs [2][8];
  logic [7:0]  m_busy [2];
  logic        m_werr [2];
  logic [7:0]  mc     [16];

  int n_checks = 0;
  int n_err    = 0;

  function automatic bit cfg_zr(int c); return (c == 0); endfunction
  function automatic bit cfg_bp(int c); return (c == 0); endfunction

  // What a read port should show right now, from the architectural rules.
  function automatic logic [31:0] m_read(int c, logic [2:0] idx);
    logic [31:0] v;
    if (!rst_n) return 32'h0;
    if (cfg_zr(c) && idx == 3'd0) return 32'h0;
    v = m_regs[c][idx];
    if (cfg_bp(c)) begin
      if (we[0] && widx[2:0] == idx) v = wdata[31:0];
      if (we[1] && widx[5:3] == idx) v = wdata[63:32];
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) m_regs[c][i] = 32'h0;
      m_busy[c] = 8'h0;
      m_werr[c] = 1'b0;
    end
  endtask

  // Apply one clock edge's worth of architectural effects (writes in port
  // order so port 1 lands last, then reservations so they beat writes).
  task automatic m_commit();
    logic [2:0] idx;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) begin
        idx = widx[p*3 +: 3];
        if (we[p] && !(cfg_zr(c) && idx == 3'd0)) begin
          m_regs[c][idx] = wdata[p*32 +: 32];
          m_busy[c][idx] = 1'b0;
        end
      end
      if (rsv && !(cfg_zr(c) && rsv_idx == 3'd0)) m_busy[c][rsv_idx] = 1'b1;
      if (we == 2'b11 && widx[2:0] == widx[5:3] && !(cfg_zr(c) && widx[2:0] == 3'd0))
        m_werr[c] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_commit();
    #1;
  endtask

  task automatic idle();
    we = 2'b00; widx = 6'h0; wdata = 64'h0; rsv = 1'b0; rsv_idx = 3'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we = 2'b11; widx = 6'o33; wdata = {32'h12345678, 32'h9ABCDEF0};
    ridx = 6'o33; rsv = 1'b1; rsv_idx = 3'd3;
    we_c = 2'b11; widx_c = 8'h21; wdata_c = 16'hBEEF; ridx_c = 16'h1122;
    rsv_c = 1'b1; rsv_idx_c = 4'd2;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rd[c] !== 64'h0) begin n_err++; $display("FAIL reset_rdata cfg%0d: got %h expected 0", c, rd[c]); end
      n_checks++;
      if (bz[c] !== 8'h0 || werr[c] !== 1'b0 || rb[c] !== 2'b00) begin
        n_err++; $display("FAIL reset_state cfg%0d: busy=%h werr=%b rbusy=%b expected 0", c, bz[c], werr[c], rb[c]);
      end
    end
    n_checks++;
    if (rd_c !== 32'h0 || bz_c !== 16'h0 || werr_c !== 1'b0) begin
      n_err++; $display("FAIL reset_wide: rdata=%h busy=%h werr=%b expected 0", rd_c, bz_c, werr_c);
    end
    @(negedge clk);
    idle(); ridx = 6'h0;
    we_c = 2'b00; rsv_c = 1'b0; widx_c = 8'h0; wdata_c = 16'h0; ridx_c = 16'h0;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bz[c] !== 8'h0 || werr[c] !== 1'b0 || rd[c] !== 64'h0) begin
        n_err++; $display("FAIL after_reset cfg%0d: busy=%h werr=%b rdata=%h expected 0", c, bz[c], werr[c], rd[c]);
      end
    end
  endtask

  task automatic test_write_bypass();
    we = 2'b01; widx = {3'd0, 3'd3}; wdata = {32'h0, 32'hDEADBEEF}; ridx = {3'd3, 3'd3};
    #1;
    n_checks++;
    if (rd[0] !== {2{32'hDEADBEEF}}) begin n_err++; $display("FAIL bypass_same_cycle: got %h expected %h", rd[0], {2{32'hDEADBEEF}}); end
    n_checks++;
    if (rd[1] !== 64'h0) begin n_err++; $display("FAIL nobypass_old_value: got %h expected 0", rd[1]); end
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rd[c] !== {2{32'hDEADBEEF}}) begin n_err++; $display("FAIL write_after_edge cfg%0d: got %h expected %h", c, rd[c], {2{32'hDEADBEEF}}); end
    end
  endtask

  task automatic test_zero_reg();
    we = 2'b11; widx = {3'd0, 3'd0}; wdata = {2{32'hFFFFFFFF}};
    rsv = 1'b1; rsv_idx = 3'd0; ridx = {3'd0, 3'd0};
    #1;
    n_checks++;
    if (rd[0] !== 64'h0) begin n_err++; $display("FAIL zero_no_bypass: got %h expected 0", rd[0]); end
    tick();
    idle();
    #1;
    n_checks++;
    if (rd[0] !== 64'h0 || bz[0][0] !== 1'b0 || werr[0] !== 1'b0) begin
      n_err++; $display("FAIL zero_reg: rdata=%h busy0=%b werr=%b expected 0/0/0", rd[0], bz[0][0], werr[0]);
    end
    // cfg 1 has no zero register: r0 is an ordinary register there
    n_checks++;
    if (rd[1][31:0] !== m_read(1, 3'd0) || bz[1] !== m_busy[1] || werr[1] !== m_werr[1]) begin
      n_err++; $display("FAIL r0_plain: rdata=%h busy=%h werr=%b expected %h/%h/%b",
                        rd[1][31:0], bz[1], werr[1], m_read(1, 3'd0), m_busy[1], m_werr[1]);
    end
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; rsv_idx = 3'd2; ridx = {3'd2, 3'd2};
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bz[c][2] !== 1'b1 || rb[c] !== 2'b11) begin
        n_err++; $display("FAIL reserve cfg%0d: busy2=%b rbusy=%b expected 1/11", c, bz[c][2], rb[c]);
      end
    end
    we = 2'b01; widx = {3'd0, 3'd2}; wdata = {32'h0, 32'h0BADF00D};
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bz[c][2] !== 1'b0) begin n_err++; $display("FAIL write_clears_busy cfg%0d: got %b expected 0", c, bz[c][2]); end
    end
    rsv = 1'b1; rsv_idx = 3'd2; we = 2'b10; widx = {3'd2, 3'd0}; wdata = {32'hC0FFEE01, 32'h0};
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bz[c][2] !== 1'b1 || rd[c][31:0] !== 32'hC0FFEE01) begin
        n_err++; $display("FAIL reserve_wins cfg%0d: busy2=%b r2=%h expected 1/c0ffee01", c, bz[c][2], rd[c][31:0]);
      end
    end
  endtask

  task automatic test_conflict();
    we = 2'b11; widx = {3'd5, 3'd5}; wdata = {32'h2222, 32'h1111}; ridx = {3'd5, 3'd5};
    #1;
    n_checks++;
    if (rd[0][31:0] !== 32'h2222) begin n_err++; $display("FAIL conflict_bypass: got %h expected 2222", rd[0][31:0]); end
    n_checks++;
    if (rd[1][31:0] !== 32'h0) begin n_err++; $display("FAIL conflict_nobypass: got %h expected 0", rd[1][31:0]); end
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rd[c][31:0] !== 32'h2222 || werr[c] !== 1'b1) begin
        n_err++; $display("FAIL conflict cfg%0d: r5=%h werr=%b expected 2222/1", c, rd[c][31:0], werr[c]);
      end
    end
    repeat (10) tick();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (werr[c] !== 1'b1) begin n_err++; $display("FAIL werr_sticky cfg%0d: got %b expected 1", c, werr[c]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we = 2'($urandom); widx = 6'($urandom); wdata = {$urandom, $urandom};
      ridx = 6'($urandom); rsv = 1'($urandom); rsv_idx = 3'($urandom);
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (rd[c][k*32 +: 32] !== m_read(c, ridx[k*3 +: 3])) begin
            n_err++; $display("FAIL rand_rdata cfg%0d port%0d: got %h expected %h", c, k, rd[c][k*32 +: 32], m_read(c, ridx[k*3 +: 3]));
          end
          n_checks++;
          if (rb[c][k] !== m_busy[c][ridx[k*3 +: 3]]) begin
            n_err++; $display("FAIL rand_rbusy cfg%0d port%0d: got %b expected %b", c, k, rb[c][k], m_busy[c][ridx[k*3 +: 3]]);
          end
        end
        n_checks++;
        if (bz[c] !== m_busy[c] || werr[c] !== m_werr[c]) begin
          n_err++; $display("FAIL rand_state cfg%0d: busy=%h werr=%b expected %h/%b", c, bz[c], werr[c], m_busy[c], m_werr[c]);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_wide();
    logic [3:0] idx;
    we_c = 2'b11;
    for (int i = 0; i < 16; i += 2) begin
      widx_c  = {4'(i + 1), 4'(i)};
      wdata_c = {8'((i + 1) * 3), 8'(i * 3)};
      tick();
      mc[i] = 8'(i * 3); mc[i + 1] = 8'((i + 1) * 3);
    end
    we_c = 2'b00;
    ridx_c = {4'd15, 4'd11, 4'd6, 4'd1};
    #1;
    n_checks++;
    if (rd_c !== {8'd45, 8'd33, 8'd18, 8'd3}) begin n_err++; $display("FAIL wide_distinct: got %h expected %h", rd_c, {8'd45, 8'd33, 8'd18, 8'd3}); end
    ridx_c = {4{4'd9}};
    #1;
    n_checks++;
    if (rd_c !== {4{8'd27}}) begin n_err++; $display("FAIL wide_same_index: got %h expected %h", rd_c, {4{8'd27}}); end
    we_c = 2'b01; widx_c = {4'd0, 4'd4}; wdata_c = {8'h00, 8'hA5}; ridx_c = {4{4'd4}};
    #1;
    n_checks++;
    if (rd_c !== {4{8'hA5}}) begin n_err++; $display("FAIL wide_bypass: got %h expected %h", rd_c, {4{8'hA5}}); end
    tick();
    mc[4] = 8'hA5;
    we_c = 2'b00;
    for (int n = 0; n < 20; n++) begin
      ridx_c = 16'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        idx = ridx_c[k*4 +: 4];
        n_checks++;
        if (rd_c[k*8 +: 8] !== mc[idx]) begin n_err++; $display("FAIL wide_rand port%0d: got %h expected %h", k, rd_c[k*8 +: 8], mc[idx]); end
      end
      tick();
    end
    n_checks++;
    if (bz_c !== 16'h0 || werr_c !== 1'b0) begin n_err++; $display("FAIL wide_state: busy=%h werr=%b expected 0/0", bz_c, werr_c); end
  endtask

  task automatic test_async_reset();
    we = 2'b11; widx = {3'd6, 3'd7}; wdata = {32'hAAAA5555, 32'h5555AAAA}; rsv = 1'b1; rsv_idx = 3'd4;
    ridx = {3'd6, 3'd7};
    tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rd[c] !== 64'h0 || bz[c] !== 8'h0 || werr[c] !== 1'b0 || rb[c] !== 2'b00) begin
        n_err++; $display("FAIL async_reset cfg%0d: rdata=%h busy=%h werr=%b rbusy=%b expected 0", c, rd[c], bz[c], werr[c], rb[c]);
      end
    end
    ridx_c = 16'h4321;
    #1;
    n_checks++;
    if (rd_c !== 32'h0 || bz_c !== 16'h0) begin n_err++; $display("FAIL async_reset_wide: rdata=%h busy=%h expected 0", rd_c, bz_c); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    we = 2'b01; widx = {3'd0, 3'd1}; wdata = {32'h0, 32'h13579BDF}; ridx = {3'd1, 3'd1};
    tick();
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rd[c][31:0] !== 32'h13579BDF || werr[c] !== 1'b0 || bz[c] !== 8'h0) begin
        n_err++; $display("FAIL first_write_after_reset cfg%0d: r1=%h werr=%b busy=%h expected 13579bdf/0/0", c, rd[c][31:0], werr[c], bz[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_conflict();
    test_random();
    test_wide();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
